// File: rtl/tap_average_if.sv
// Bundles the four tap inputs and the window results of tap_average.
// The master side drives samples and reads results; the slave side is the window processor.
interface tap_average_if #(
   parameter int W     = 8,
   parameter int CNT_W = 16
);
   logic             din_valid;
   logic [W-1:0]     tap0;
   logic [W-1:0]     tap1;
   logic [W-1:0]     tap2;
   logic [W-1:0]     tap3;
   logic [W-1:0]     avg;
   logic [W-1:0]     peak;
   logic             out_valid;
   logic [CNT_W-1:0] res_count;

   modport master (
      output din_valid, tap0, tap1, tap2, tap3,
      input  avg, peak, out_valid, res_count
   );

   modport slave (
      input  din_valid, tap0, tap1, tap2, tap3,
      output avg, peak, out_valid, res_count
   );
endinterface

// File: rtl/tap_average.sv
// Two-stage 4-tap window processor: rounded mean, maximum and result counter.
// Define TAP_AVERAGE_ROUND_EN for round-half-up averaging; otherwise the mean truncates.
module tap_average #(
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst,
   tap_average_if.slave  bus
);

   logic [3:0]       r_vmask;
   logic [W:0]       r_s01;
   logic [W:0]       r_s23;
   logic [W-1:0]     r_m01;
   logic [W-1:0]     r_m23;
   logic             r_v1;

   logic [W-1:0]     r_avg;
   logic [W-1:0]     r_peak;
   logic             r_outValid;
   logic [CNT_W-1:0] r_resCount;

   logic [W+1:0]     w_sum;
   logic [W+1:0]     w_rounded;
   logic [W+1:0]     w_quot;
   logic [W-1:0]     w_avg;
   logic [W-1:0]     w_peak;

   // The mask shifts with the upstream register, so it describes the taps presented now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vmask <= '0;
         r_s01   <= '0;
         r_s23   <= '0;
         r_m01   <= '0;
         r_m23   <= '0;
         r_v1    <= 1'b0;
      end else begin
         r_vmask <= {r_vmask[2:0], bus.din_valid};
         r_s01   <= {1'b0, bus.tap0} + {1'b0, bus.tap1};
         r_s23   <= {1'b0, bus.tap2} + {1'b0, bus.tap3};
         r_m01   <= (bus.tap0 >= bus.tap1) ? bus.tap0 : bus.tap1;
         r_m23   <= (bus.tap2 >= bus.tap3) ? bus.tap2 : bus.tap3;
         r_v1    <= (r_vmask == 4'b1111);
      end
   end

   assign w_sum = {1'b0, r_s01} + {1'b0, r_s23};

`ifdef TAP_AVERAGE_ROUND_EN
   assign w_rounded = w_sum + (W+2)'(2);
`else
   assign w_rounded = w_sum;
`endif

   assign w_quot = w_rounded >> 2;
   assign w_avg  = (|w_quot[W+1:W]) ? '1 : w_quot[W-1:0];
   assign w_peak = (r_m01 >= r_m23) ? r_m01 : r_m23;

   // Results only move on a valid window so the consumer sees stable data between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_avg      <= '0;
         r_peak     <= '0;
         r_outValid <= 1'b0;
         r_resCount <= '0;
      end else begin
         r_outValid <= r_v1;
         if (r_v1) begin
            r_avg      <= w_avg;
            r_peak     <= w_peak;
            r_resCount <= r_resCount + 1'b1;
         end
      end
   end

   assign bus.avg       = r_avg;
   assign bus.peak      = r_peak;
   assign bus.out_valid = r_outValid;
   assign bus.res_count = r_resCount;

endmodule

// File: tb/tb_tap_average.sv
// Scoreboard bench for tap_average: a 16-bit and a 4-bit counter instance share one stimulus stream.
// Expected results are queued with the edge they should appear on and checked by a separate monitor.
module tb_tap_average;

   localparam int W = 8;

`ifdef TAP_AVERAGE_ROUND_EN
   localparam bit RoundEn = 1'b1;
`else
   localparam bit RoundEn = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [7:0]  avg;
      logic [7:0]  peak;
      logic [15:0] cnt;
   } expT;

   logic clk = 1'b0;
   logic rst = 1'b1;

   expT         sbQ[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [3:0]  mVmask = 4'b0000;
   logic [15:0] mCount = 16'd0;
   logic [7:0]  lastAvg = 8'd0;
   logic [7:0]  lastPeak = 8'd0;
   bit          monEn = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   tap_average_if #(.W(W), .CNT_W(16)) bus ();
   tap_average_if #(.W(W), .CNT_W(4))  busSmall ();

   assign busSmall.din_valid = bus.din_valid;
   assign busSmall.tap0      = bus.tap0;
   assign busSmall.tap1      = bus.tap1;
   assign busSmall.tap2      = bus.tap2;
   assign busSmall.tap3      = bus.tap3;

   tap_average #(.W(W), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   tap_average #(.W(W), .CNT_W(4)) dutSmall (
      .clk (clk),
      .rst (rst),
      .bus (busSmall)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // One call drives the inputs seen by exactly one rising edge.
   task automatic applyStimulus(input logic dv, input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] t2, input logic [7:0] t3,
                                input logic [7:0] avgTrunc, input logic [7:0] avgRound,
                                input logic [7:0] pk);
      expT e;
      @(negedge clk);
      bus.din_valid = dv;
      bus.tap0 = t0;
      bus.tap1 = t1;
      bus.tap2 = t2;
      bus.tap3 = t3;
      if (mVmask == 4'b1111) begin
         mCount = mCount + 16'd1;
         e.cyc  = cyc + 2;
         e.avg  = RoundEn ? avgRound : avgTrunc;
         e.peak = pk;
         e.cnt  = mCount;
         sbQ.push_back(e);
      end
      mVmask = {mVmask[2:0], dv};
   endtask

   task automatic applyConstant(input int n, input logic [7:0] v);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b1, v, v, v, v, v, v, v);
   endtask

   task automatic doReset();
      @(posedge clk);
      #2;
      checkOutput("preResetValid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      bus.din_valid = 1'b0;
      sbQ.delete();
      mVmask = 4'b0000;
      mCount = 16'd0;
      lastAvg = 8'd0;
      lastPeak = 8'd0;
      #1;
      checkOutput("rstAvg", 32'(bus.avg), 32'd0);
      checkOutput("rstPeak", 32'(bus.peak), 32'd0);
      checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
      checkOutput("rstCount", 32'(bus.res_count), 32'd0);
      checkOutput("rstCountSmall", 32'(busSmall.res_count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: pop on the tagged edge, otherwise require idle with held data.
   initial begin
      expT e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && monEn) begin
            if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
               e = sbQ.pop_front();
               checkOutput("outValid", 32'(bus.out_valid), 32'd1);
               checkOutput("avg", 32'(bus.avg), 32'(e.avg));
               checkOutput("peak", 32'(bus.peak), 32'(e.peak));
               checkOutput("resCount", 32'(bus.res_count), 32'(e.cnt));
               checkOutput("resCountSmall", 32'(busSmall.res_count), 32'(e.cnt[3:0]));
               lastAvg = e.avg;
               lastPeak = e.peak;
            end else begin
               checkOutput("idleValid", 32'(bus.out_valid), 32'd0);
               checkOutput("holdAvg", 32'(bus.avg), 32'(lastAvg));
               checkOutput("holdPeak", 32'(bus.peak), 32'(lastPeak));
            end
         end
      end
   end

   initial begin
      bus.din_valid = 1'b0;
      bus.tap0 = '0;
      bus.tap1 = '0;
      bus.tap2 = '0;
      bus.tap3 = '0;
      #1;
      checkOutput("initAvg", 32'(bus.avg), 32'd0);
      checkOutput("initPeak", 32'(bus.peak), 32'd0);
      checkOutput("initValid", 32'(bus.out_valid), 32'd0);
      checkOutput("initCount", 32'(bus.res_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      monEn = 1'b1;

      // Long constant run: 18 results, enough to wrap the 4-bit counter.
      applyConstant(22, 8'd100);

      //            dv    t0    t1    t2    t3   trunc  round  peak
      applyStimulus(1'b1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd1, 8'd2, 8'd2);
      applyStimulus(1'b1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
      applyStimulus(1'b1, 8'd3, 8'd200, 8'd17, 8'd199, 8'd104, 8'd105, 8'd200);
      applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1);
      applyStimulus(1'b1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1);
      applyStimulus(1'b1, 8'd7, 8'd7, 8'd7, 8'd8, 8'd7, 8'd7, 8'd8);

      // A single din_valid gap: this window is still valid, the next four are blocked.
      applyStimulus(1'b0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd25, 8'd25, 8'd40);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
      applyStimulus(1'b1, 8'd50, 8'd60, 8'd70, 8'd80, 8'd65, 8'd65, 8'd80);

      applyConstant(6, 8'd100);
      doReset();
      applyConstant(10, 8'd100);

      for (int i = 0; i < 7; i++)
         applyStimulus(1'b0, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);

      @(posedge clk);
      #2;
      checkOutput("queueDrained", 32'(sbQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
